// File: rtl/input_conditioner.sv
// Per-channel synchronizer + debouncer with registered rise/fall pulses and optional sticky edge capture.
// Optional feature macro: INPUT_CONDITIONER_EDGE_CAPTURE_EN (edge_capture register, edge_clr, irq).
module input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] w_differ;
    logic [WIDTH-1:0] w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    // A channel accepts its new level on the edge where the count has reached its last value.
    always_comb begin
        w_differ = r_sync2 ^ r_stable;
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = w_differ[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_differ[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_stable <= r_stable ^ w_accept;
            r_rise   <= w_accept & r_sync2;
            r_fall   <= w_accept & ~r_sync2;
        end
    end

    assign stable_out = r_stable;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

`ifdef INPUT_CONDITIONER_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] r_capture;

    // A new edge on the same cycle as a clear strobe keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_capture <= '0;
        end else begin
            r_capture <= (r_capture & ~edge_clr) | w_accept;
        end
    end

    assign edge_capture = r_capture;
    assign irq          = |r_capture;
`else
    logic w_unused_edge_clr;

    assign w_unused_edge_clr = ^edge_clr;
    assign edge_capture      = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (WIDTH=8, DEBOUNCE_CYCLES=4); capture expectations follow INPUT_CONDITIONER_EDGE_CAPTURE_EN.
module tb_input_conditioner;

    localparam int W  = 8;
    localparam int DB = 4;
`ifdef INPUT_CONDITIONER_EDGE_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] edge_clr = '0;
    logic [W-1:0] stable_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] edge_capture;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    input_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_in       (raw_in),
        .edge_clr     (edge_clr),
        .stable_out   (stable_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .edge_capture (edge_capture),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cap is the capture value expected when the feature is built in.
    task automatic check_outs(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                              input logic [W-1:0] fa, input logic [W-1:0] cap);
        logic [W-1:0] exp_cap;
        logic [W-1:0] exp_irq;
        exp_cap = CAP_EN ? cap : '0;
        exp_irq = {{(W-1){1'b0}}, |exp_cap};
        check({tag, ".stable"}, stable_out, st);
        check({tag, ".rise"}, rise_pulse, ri);
        check({tag, ".fall"}, fall_pulse, fa);
        check({tag, ".cap"}, edge_capture, exp_cap);
        check({tag, ".irq"}, {{(W-1){1'b0}}, irq}, exp_irq);
    endtask

    initial begin
        // Reset held with inputs active: everything stays 0.
        raw_in = 8'hFF;
        repeat (3) tick();
        check_outs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        raw_in  = 8'h00;
        reset_n = 1'b1;
        repeat (3) tick();
        check_outs("idle", 8'h00, 8'h00, 8'h00, 8'h00);

        // Bounce: high 3 cycles then low; never accepted.
        raw_in = 8'h01;
        repeat (3) tick();
        raw_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outs("bounce", 8'h00, 8'h00, 8'h00, 8'h00);
        end

        // Clean press: accepted on the 6th edge after the change.
        raw_in = 8'h01;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("press_wait", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        tick();
        check_outs("press_acc", 8'h01, 8'h01, 8'h00, 8'h01);
        tick();
        check_outs("press_hold", 8'h01, 8'h00, 8'h00, 8'h01);

        // Release with clear strobe landing on the accepting edge.
        raw_in = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("rel_wait", 8'h01, 8'h00, 8'h00, 8'h01);
        end
        edge_clr = 8'h01;
        tick();
        check_outs("collide", 8'h00, 8'h00, 8'h01, 8'h01);
        edge_clr = 8'h00;
        tick();
        check_outs("collide_after", 8'h00, 8'h00, 8'h00, 8'h01);

        // Clear with no event, plus simultaneous rise on bits 0 and 7.
        edge_clr = 8'h01;
        raw_in   = 8'h81;
        tick();
        check_outs("clear", 8'h00, 8'h00, 8'h00, 8'h00);
        edge_clr = 8'h00;
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_outs("multi_wait", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        tick();
        check_outs("multi_acc", 8'h81, 8'h81, 8'h00, 8'h81);
        tick();
        check_outs("multi_hold", 8'h81, 8'h00, 8'h00, 8'h81);

        // Reset mid-count, then a held 0x01 through release.
        raw_in = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_outs("mid_wait", 8'h81, 8'h00, 8'h00, 8'h81);
        end
        reset_n = 1'b0;
        #1;
        check_outs("rst_async", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        check_outs("rst_hold", 8'h00, 8'h00, 8'h00, 8'h00);
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("post_wait", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        tick();
        check_outs("post_acc", 8'h01, 8'h01, 8'h00, 8'h01);
        tick();
        check_outs("post_hold", 8'h01, 8'h00, 8'h00, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
